pc_sequencer: RTL and testbench

- Program-counter and fetch sequencer for the 9-bit CPU. It sits directly upstream of instruction decode.
- It drives the instruction-memory address and presents the fetched 9-bit word plus a valid strobe to decode/execute.
- It resolves the four conditional control-flow opcodes locally: jizr, jnzr, bizr, bnzr.
- It detects the func/done halt.
- It owns the start/done handshake with the testbench or host.

---
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the 9-bit CPU: drives the instruction
// address, resolves jizr/jnzr/bizr/bnzr locally and owns the start/done handshake.
module pc_sequencer #(
    parameter int PC_W     = 10,
    parameter int START_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [8:0]       instr_i,
    input  logic             zero_i,
    input  logic [8:0]       reg_val_i,
    input  logic             stall_i,
    output logic [PC_W-1:0]  pc_o,
    output logic [8:0]       instr_o,
    output logic             valid_o,
    output logic             done_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [4:0] OP_JIZR = 5'd20;
    localparam logic [4:0] OP_JNZR = 5'd21;
    localparam logic [4:0] OP_BIZR = 5'd22;
    localparam logic [4:0] OP_BNZR = 5'd23;
    localparam logic [4:0] OP_FUNC = 5'd31;

    localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);

    logic [1:0]       state, state_nxt;
    logic [PC_W-1:0]  pc, pc_nxt;
    logic [CNT_W-1:0] retired, retired_nxt;

    logic [4:0]      opcode;
    logic            is_done;
    logic            jump_taken;
    logic            branch_taken;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] branch_offset;

    assign opcode        = instr_i[8:4];
    assign is_done       = (opcode == OP_FUNC) && (instr_i[1:0] == 2'b11);
    assign jump_taken    = ((opcode == OP_JIZR) && zero_i) || ((opcode == OP_JNZR) && !zero_i);
    assign branch_taken  = ((opcode == OP_BIZR) && zero_i) || ((opcode == OP_BNZR) && !zero_i);
    // Jump targets are zero-extended, branch offsets are 9-bit two's complement.
    assign jump_target   = PC_W'(reg_val_i);
    assign branch_offset = PC_W'($signed(reg_val_i));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt   = state;
        pc_nxt      = pc;
        retired_nxt = retired;
        case (state)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    state_nxt   = S_RUN;
                    pc_nxt      = START_PC_V;
                    retired_nxt = '0;
                end
            end
            S_RUN: begin
                // Decode is only looked at here, so X on instr_i/zero_i outside RUN is harmless.
                if (!stall_i) begin
                    if (retired != '1) retired_nxt = retired + CNT_W'(1);
                    if (is_done)           state_nxt = S_HALT;
                    else if (jump_taken)   pc_nxt    = jump_target;
                    else if (branch_taken) pc_nxt    = pc + branch_offset;
                    else                   pc_nxt    = pc + PC_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= START_PC_V;
            retired <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignment so all flops update together.
            state   <= state_nxt;
            pc      <= pc_nxt;
            retired <= retired_nxt;
        end
    end

    assign pc_o      = pc;
    assign instr_o   = instr_i;
    assign valid_o   = (state == S_RUN) && !stall_i;
    assign done_o    = (state == S_HALT);
    assign retired_o = retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a bench-owned instruction memory feeds instr_i
// from pc_o, and each step is compared against hand-computed PC/counter values.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        zero;
    logic [8:0]  reg_val;
    logic        stall;
    logic [9:0]  pc;
    logic [8:0]  instr, instr_out;
    logic        valid, done;
    logic [15:0] retired;

    logic [9:0]  pc2;
    logic [8:0]  instr_out2;
    logic        valid2, done2;
    logic [2:0]  retired2;

    logic [8:0]  mem [0:1023];

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    assign instr = mem[pc];

    pc_sequencer #(.PC_W(10), .START_PC(0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .instr_i(instr), .zero_i(zero),
        .reg_val_i(reg_val), .stall_i(stall), .pc_o(pc), .instr_o(instr_out),
        .valid_o(valid), .done_o(done), .retired_o(retired)
    );

    // Narrow counter copy running NOPs only, to reach counter saturation quickly.
    pc_sequencer #(.PC_W(10), .START_PC(0), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start_i(start), .instr_i(9'h000), .zero_i(1'b0),
        .reg_val_i(9'h000), .stall_i(stall), .pc_o(pc2), .instr_o(instr_out2),
        .valid_o(valid2), .done_o(done2), .retired_o(retired2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One retiring RUN cycle: PC must land on exp_pc and the counter must advance.
    task automatic adv(input string tag, input int exp_pc);
        tick();
        exp_ret++;
        check(tag, 32'(pc), 32'(exp_pc));
        check({tag, "_ret"}, 32'(retired), 32'(exp_ret));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
        mem[3]  = 9'h1F3;
        rst_n   = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        zero    = 1'b0;
        reg_val = 9'h000;

        #12;
        check("rst_pc", 32'(pc), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ret", 32'(retired), 0);
        check("instr_pass", 32'(instr_out), 32'h000);
        rst_n = 1'b1;
        tick();
        check("idle_valid", 32'(valid), 0);
        check("idle_pc", 32'(pc), 0);

        // Straight-line NOPs into done at address 3.
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_ret = 0;
        check("run_pc0", 32'(pc), 0);
        check("run_valid", 32'(valid), 1);
        adv("pc1", 1);
        adv("pc2", 2);
        adv("pc3", 3);
        check("pc3_done", 32'(done), 0);
        check("done_instr", 32'(instr_out), 32'h1F3);
        tick();
        exp_ret++;
        check("halt_done", 32'(done), 1);
        check("halt_pc", 32'(pc), 3);
        check("halt_valid", 32'(valid), 0);
        check("halt_ret", 32'(retired), 4);
        tick();
        check("halt_hold_pc", 32'(pc), 3);
        check("halt_hold_done", 32'(done), 1);

        // Control-flow program.
        mem[1]    = 9'h1F0;  // func, not done
        mem[3]    = 9'h000;
        mem[5]    = 9'h140;  // jizr
        mem[6]    = 9'h170;  // bnzr
        mem[40]   = 9'h150;  // jnzr
        mem[8]    = 9'h160;  // bizr
        mem[10]   = 9'h170;  // bnzr
        mem[11]   = 9'h170;  // bnzr
        mem[1023] = 9'h000;

        // Start with stall also high in HALT: start wins.
        start = 1'b1;
        stall = 1'b1;
        tick();
        check("restart_pc", 32'(pc), 0);
        check("restart_ret", 32'(retired), 0);
        check("restart_done", 32'(done), 0);
        check("restart_stall_valid", 32'(valid), 0);
        start = 1'b0;
        stall = 1'b0;
        exp_ret = 0;

        adv("nop_to1", 1);
        adv("func_plain", 2);
        start = 1'b1;
        adv("start_in_run", 3);
        check("start_in_run_done", 32'(done), 0);
        start = 1'b0;
        adv("to4", 4);
        adv("to5", 5);
        reg_val = 9'd40;
        zero    = 1'b0;
        adv("jizr_nt", 6);
        reg_val = 9'h1FF;
        adv("bnzr_back", 5);
        reg_val = 9'd40;
        zero    = 1'b1;
        adv("jizr_t", 40);
        reg_val = 9'd10;
        zero    = 1'b0;
        adv("jnzr_t", 10);
        reg_val = 9'h1FD;
        adv("bnzr_m3", 7);
        adv("to8", 8);
        adv("bizr_nt", 9);
        adv("to10", 10);
        zero = 1'b1;
        adv("bnzr_nt", 11);
        zero    = 1'b0;
        reg_val = 9'h000;
        adv("bnzr_zero", 11);
        reg_val = 9'h1F5;
        mem[0]  = 9'h170;
        adv("bnzr_m11", 0);
        reg_val = 9'h1FF;
        adv("wrap_down", 1023);
        adv("wrap_up", 0);
        zero = 1'b1;
        adv("at0_nt", 1);
        adv("func_plain2", 2);
        adv("to3", 3);
        mem[4] = 9'h1F3;
        adv("to4_done", 4);

        // Stall on the done instruction for three cycles.
        stall = 1'b1;
        #1;
        check("stall_valid", 32'(valid), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", 32'(pc), 4);
            check("stall_valid_hold", 32'(valid), 0);
            check("stall_ret", 32'(retired), 32'(exp_ret));
            check("stall_done", 32'(done), 0);
        end
        stall = 1'b0;
        #1;
        check("unstall_valid", 32'(valid), 1);
        tick();
        exp_ret++;
        check("halt2_done", 32'(done), 1);
        check("halt2_pc", 32'(pc), 4);
        check("halt2_ret", 32'(retired), 32'(exp_ret));
        check("sat_ret", 32'(retired2), 7);

        // Restart, then asynchronous reset between clock edges.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart2_pc", 32'(pc), 0);
        check("restart2_ret", 32'(retired), 0);
        tick();
        tick();
        check("pre_rst_pc", 32'(pc), 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_pc", 32'(pc), 0);
        check("async_valid", 32'(valid), 0);
        check("async_ret", 32'(retired), 0);
        check("async_done", 32'(done), 0);
        check("async_sat_ret", 32'(retired2), 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_pc", 32'(pc), 0);
            check("post_rst_valid", 32'(valid), 0);
            check("post_rst_done", 32'(done), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
